dmem_block_painter: RTL

- Write-side counterpart of the VGA display path. Accepts drawing commands (plot, rectangle fill, full-screen clear) over a valid/ready handshake.
- Converts each command into one-word-per-cycle writes into the display memory, which the VGA scan-out reads.
- Memory layout: 20x15 grid of 32x32-pixel blocks, row-major, address = BASE_ADDR + y*20 + x.
- Word format: bits [2:0] = {b,g,r}; bits [31:3] = 0.

---
 rtl/dmem_block_painter_if.sv | 31 +++
 rtl/dmem_block_painter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dmem_block_painter_if.sv
// Command and display-memory write bus of the block painter.
// slave: painter side (takes commands, drives memory writes).
// master: command source / memory side.
interface dmem_block_painter_if #(
  parameter int ADDR_W = 12
);
  logic              iCMD_VALID;
  logic              oCMD_READY;
  logic [1:0]        iCMD_OP;
  logic [4:0]        iX;
  logic [3:0]        iY;
  logic [4:0]        iW;
  logic [3:0]        iH;
  logic [2:0]        iCOLOR;
  logic              oWREN;
  logic [ADDR_W-1:0] oWADDR;
  logic [31:0]       oWDATA;
  logic              oBUSY;
  logic              oDONE;
  logic              oERR;

  modport slave (
    input  iCMD_VALID, iCMD_OP, iX, iY, iW, iH, iCOLOR,
    output oCMD_READY, oWREN, oWADDR, oWDATA, oBUSY, oDONE, oERR
  );

  modport master (
    output iCMD_VALID, iCMD_OP, iX, iY, iW, iH, iCOLOR,
    input  oCMD_READY, oWREN, oWADDR, oWDATA, oBUSY, oDONE, oERR
  );
endinterface

// File: rtl/dmem_block_painter.sv
// Block painter: turns PLOT / FILL / CLEAR commands into one-word-per-cycle
// writes into the 20x15 block display memory (address = base + y*20 + x).
// Optional build macro BOUNDS_CLIP_EN: out-of-range rectangles are clipped
// to the screen instead of being rejected.
module dmem_block_painter #(
  parameter int H_BLOCKS  = 20,
  parameter int V_BLOCKS  = 15,
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input logic                 iCLK,
  input logic                 iRST,
  dmem_block_painter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [1:0] OP_PLOT  = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;
  localparam logic [5:0] H_LIM    = 6'(H_BLOCKS);
  localparam logic [4:0] V_LIM    = 5'(V_BLOCKS);

  state_t            state, state_next;
  logic [1:0]        op;
  logic [4:0]        x, w, col;
  logic [3:0]        y, h, row;
  logic [2:0]        color;
  logic              wren, done, err, busy;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  logic [5:0]        x_end;
  logic [4:0]        y_end;
  logic              x_oob, y_oob, x_over, y_over;
  logic              cmd_bad, cmd_empty;
  logic [4:0]        run_w;
  logic [3:0]        run_h;
  logic [ADDR_W-1:0] start_addr, row_step;
  logic              last_col, last_row, accept;

  assign accept         = bus.iCMD_VALID && (state == IDLE);
  assign bus.oCMD_READY = (state == IDLE);
  assign bus.oWREN      = wren;
  assign bus.oWADDR     = waddr;
  assign bus.oWDATA     = wdata;
  assign bus.oBUSY      = busy;
  assign bus.oDONE      = done;
  assign bus.oERR       = err;

  // Row stride without a multiplier: y*20 = (y<<4) + (y<<2).
  assign start_addr = ADDR_W'(BASE_ADDR) + (ADDR_W'(y) << 4) + (ADDR_W'(y) << 2) + ADDR_W'(x);
  assign row_step   = ADDR_W'(H_BLOCKS) - ADDR_W'(w) + ADDR_W'(1);
  assign last_col   = (col == w - 5'd1);
  assign last_row   = (row == h - 4'd1);

  // Validate the latched command and derive the rectangle actually painted.
  always_comb begin
    x_end  = {1'b0, x} + {1'b0, w};
    y_end  = {1'b0, y} + {1'b0, h};
    x_oob  = ({1'b0, x} >= H_LIM);
    y_oob  = ({1'b0, y} >= V_LIM);
    x_over = (x_end > H_LIM);
    y_over = (y_end > V_LIM);
`ifdef BOUNDS_CLIP_EN
    cmd_bad   = (op == OP_RSVD);
    cmd_empty = x_oob || y_oob || (w == 5'd0) || (h == 4'd0);
    run_w     = x_over ? 5'(H_LIM - {1'b0, x}) : w;
    run_h     = y_over ? 4'(V_LIM - {1'b0, y}) : h;
`else
    cmd_bad   = (op == OP_RSVD) || x_oob || y_oob || x_over || y_over;
    cmd_empty = (w == 5'd0) || (h == 4'd0);
    run_w     = w;
    run_h     = h;
`endif
  end

  // Next-state decode of the command sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? SETUP : IDLE;
      SETUP:   state_next = (cmd_bad || cmd_empty) ? FINISH : RUN;
      RUN:     state_next = (last_col && last_row) ? FINISH : RUN;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any command in flight.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= state_next;
  end

  // Command latch, raster counters and registered memory-write outputs.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      op <= 2'd0; x <= 5'd0; y <= 4'd0; w <= 5'd0; h <= 4'd0; color <= 3'd0;
      col <= 5'd0; row <= 4'd0;
      wren <= 1'b0; waddr <= '0; wdata <= 32'd0;
      done <= 1'b0; err <= 1'b0; busy <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          wren <= 1'b0;
          done <= 1'b0;
          err  <= 1'b0;
          if (accept) begin
            op    <= bus.iCMD_OP;
            color <= bus.iCOLOR;
            case (bus.iCMD_OP)
              OP_PLOT: begin
                x <= bus.iX; y <= bus.iY; w <= 5'd1; h <= 4'd1;
              end
              OP_CLEAR: begin
                x <= 5'd0; y <= 4'd0; w <= 5'(H_BLOCKS); h <= 4'(V_BLOCKS);
              end
              default: begin
                x <= bus.iX; y <= bus.iY; w <= bus.iW; h <= bus.iH;
              end
            endcase
          end
        end
        SETUP: begin
          w   <= run_w;
          h   <= run_h;
          col <= 5'd0;
          row <= 4'd0;
          if (cmd_bad) begin
            err <= 1'b1;
          end else if (cmd_empty) begin
            done <= 1'b1;
          end else begin
            wren  <= 1'b1;
            waddr <= start_addr;
            wdata <= {29'd0, color};
          end
        end
        RUN: begin
          if (last_col) begin
            col <= 5'd0;
            if (last_row) begin
              wren <= 1'b0;
              done <= 1'b1;
            end else begin
              row   <= row + 4'd1;
              waddr <= waddr + row_step;
            end
          end else begin
            col   <= col + 5'd1;
            waddr <= waddr + ADDR_W'(1);
          end
        end
        FINISH: begin
          wren <= 1'b0;
          done <= 1'b0;
          err  <= 1'b0;
        end
        default: begin
          wren <= 1'b0;
          done <= 1'b0;
          err  <= 1'b0;
        end
      endcase
    end
  end

endmodule
